// File: rtl/sample_period_meter.sv
// rtl/sample_period_meter.sv - strobe period meter with lock and timeout detection
module sample_period_meter #(
  parameter logic [31:0] CLK_PERIOD_NS  = 32'd10,
  parameter int          SYNC_STAGES    = 2,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'hFFFF_FFFF,
  parameter logic [31:0] LOCK_COUNT     = 32'd4,
  parameter logic [31:0] TOL_CYCLES     = 32'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        strobe_in,
  output logic        period_valid,
  output logic [31:0] period_cycles,
  output logic [31:0] period_ns,
  output logic        locked,
  output logic        timeout
);

  typedef enum logic {
    IDLE = 1'b0,
    MEAS = 1'b1
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        s;
  logic        s_d;
  logic        strobe_edge;
  logic [31:0] cnt;
  logic [31:0] match_cnt;
  logic [31:0] match_d;
  logic [31:0] prev_period;
  logic [31:0] diff;
  logic [63:0] product;
  logic [31:0] ns_sat;
  logic        meas_d;
  logic        tmo_d;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = strobe_in;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;

      // Shift strobe_in through the synchroniser chain.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= strobe_in;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end

      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Delay the synchronised strobe by one cycle for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_d <= 1'b0;
    end else begin
      s_d <= s;
    end
  end

  assign strobe_edge = s & ~s_d;

  // Cycles since the last edge; restarts at 1 on an edge, parks at the timeout value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (strobe_edge) begin
      cnt <= 32'd1;
    end else if (cnt < TIMEOUT_CYCLES) begin
      cnt <= cnt + 32'd1;
    end
  end

  // Full-width product so that large periods saturate instead of wrapping.
  assign product = {32'd0, cnt} * {32'd0, CLK_PERIOD_NS};
  assign ns_sat  = (product[63:32] != 32'd0) ? 32'hFFFF_FFFF : product[31:0];
  assign diff    = (cnt >= prev_period) ? (cnt - prev_period) : (prev_period - cnt);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, measurement/timeout strobes and the next match count.
  always_comb begin
    state_d = state_q;
    meas_d  = 1'b0;
    tmo_d   = 1'b0;
    match_d = match_cnt;
    case (state_q)
      IDLE: begin
        if (strobe_edge) begin
          state_d = MEAS;
        end
      end
      MEAS: begin
        if (strobe_edge) begin
          meas_d = 1'b1;
          if (match_cnt == 32'd0) begin
            match_d = 32'd1;
          end else if (diff <= TOL_CYCLES) begin
            match_d = (match_cnt >= LOCK_COUNT) ? LOCK_COUNT : (match_cnt + 32'd1);
          end else begin
            match_d = 32'd1;
          end
        end else if (cnt == TIMEOUT_CYCLES) begin
          tmo_d   = 1'b1;
          match_d = 32'd0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Register the outputs; period values hold across a timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_valid  <= 1'b0;
      period_cycles <= '0;
      period_ns     <= '0;
      locked        <= 1'b0;
      timeout       <= 1'b0;
      match_cnt     <= '0;
      prev_period   <= '0;
    end else begin
      period_valid <= meas_d;
      timeout      <= tmo_d;
      match_cnt    <= match_d;
      if (meas_d) begin
        period_cycles <= cnt;
        period_ns     <= ns_sat;
        prev_period   <= cnt;
        locked        <= (match_d >= LOCK_COUNT);
      end else if (tmo_d) begin
        locked <= 1'b0;
      end
    end
  end

endmodule
